// File: rtl/seq_mul_unit_if.sv
// Handshake and data bundle for the sequential multiplier: operand side (in_*, A, B,
// signed_mode) and result side (out_*, product, zero).
interface seq_mul_unit_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 signed_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 zero;

  modport master (
    output in_valid, A, B, signed_mode, out_ready,
    input  in_ready, out_valid, product, zero
  );

  modport slave (
    input  in_valid, A, B, signed_mode, out_ready,
    output in_ready, out_valid, product, zero
  );
endinterface

// File: rtl/seq_mul_unit.sv
// Radix-2 shift-add multiplier, one partial product per clock, sign-magnitude handling
// for signed mode. Fixed latency of WIDTH edges from accept to out_valid.
module seq_mul_unit #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_mul_unit_if.slave bus
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int            PW   = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_next;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic            neg;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   acc_sum;
  logic [PW-1:0]   partial;
  logic [PW-1:0]   product_q;
  logic            zero_q;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  // Negating the most negative value yields 2^(WIDTH-1), still exact as an unsigned magnitude.
  assign a_abs = (bus.signed_mode && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign b_abs = (bus.signed_mode && bus.B[WIDTH-1]) ? -bus.B : bus.B;

  assign partial = mag_b[cnt] ? (PW'(mag_a) << cnt) : '0;
  assign acc_sum = acc + partial;

  always_comb begin
    // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = RUN;
      RUN:     if (cnt == LAST)   state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mag_a     <= '0;
      mag_b     <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      product_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mag_a <= a_abs;
            mag_b <= b_abs;
            neg   <= bus.signed_mode & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= acc_sum;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            product_q <= neg ? -acc_sum : acc_sum;
            zero_q    <= (acc_sum == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.product   = product_q;
  assign bus.zero      = zero_q;
endmodule
